// File: rtl/detector_forma_onda.sv
// detector_forma_onda: measures high/low run lengths of a periodic waveform,
// reports each completed period and declares lock once the pattern repeats.
//
// Parameters:
//   LARGURA  - run-counter width; legal runs are 1 .. 2^LARGURA-1 cycles
//   CONFIRMA - consecutive matching periods needed to raise Travado
// Ports:
//   Clock   in   single clock, posedge
//   Reset   in   synchronous, active-high
//   Entrada in   waveform under measurement
//   Alto    out  high-run length of the last completed period
//   Baixo   out  low-run length of the last completed period
//   Periodo out  Alto + Baixo of the last completed period
//   Valido  out  one-cycle pulse when a period completes
//   Travado out  pattern locked
//   Erro    out  sticky run-overflow flag
// Optional feature: define FILTRO_GLITCH_EN to add a 2-flop synchronizer and
// a two-equal-sample glitch filter in front of the edge detector.

module detector_forma_onda #(
    parameter int LARGURA  = 3,
    parameter int CONFIRMA = 2
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Entrada,
    output logic [LARGURA-1:0] Alto,
    output logic [LARGURA-1:0] Baixo,
    output logic [LARGURA:0]   Periodo,
    output logic               Valido,
    output logic               Travado,
    output logic               Erro
);

    localparam int AW = (CONFIRMA < 1) ? 1 : $clog2(CONFIRMA + 1);
    localparam logic [LARGURA-1:0] CNT_MAX    = '1;
    localparam logic [LARGURA-1:0] CNT_UM     = LARGURA'(1);
    localparam logic [AW-1:0]      ACERTO_MAX = AW'(CONFIRMA);

    typedef enum logic [1:0] {
        INICIO = 2'd0,
        ALTO   = 2'd1,
        BAIXO  = 2'd2
    } estado_t;

    logic               s0_q, s0_d;
    logic               s1_q, s1_d;
    logic [LARGURA-1:0] cnt_q, cnt_d;
    estado_t            estado_q, estado_d;
    logic [LARGURA-1:0] alto_cur_q, alto_cur_d;
    logic [LARGURA-1:0] alto_q, alto_d;
    logic [LARGURA-1:0] baixo_q, baixo_d;
    logic [LARGURA:0]   periodo_q, periodo_d;
    logic               valido_q, valido_d;
    logic               travado_q, travado_d;
    logic               erro_q, erro_d;
    logic [AW-1:0]      acerto_q, acerto_d;
    logic               ha_ref_q, ha_ref_d;

    logic borda;
    logic subida;
    logic descida;
    logic estouro;

`ifdef FILTRO_GLITCH_EN
    logic y1_q, y2_q, y3_q;

    // Synchronizer (y1, y2) plus one more stage so that a level is only
    // accepted when two consecutive synchronized samples agree.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            y1_q <= 1'b1;
            y2_q <= 1'b1;
            y3_q <= 1'b1;
        end else begin
            y1_q <= Entrada;
            y2_q <= y1_q;
            y3_q <= y2_q;
        end
    end

    always_comb begin
        s0_d = s0_q;
        if (y2_q == y3_q) begin
            s0_d = y2_q;
        end
    end
`else
    always_comb begin
        s0_d = Entrada;
    end
`endif

    assign borda   = s0_q ^ s1_q;
    assign subida  = s0_q & ~s1_q;
    assign descida = ~s0_q & s1_q;

    // A run that reaches the counter maximum without ending is one cycle
    // too long; an edge at the maximum is still a legal run.
    assign estouro = (estado_q != INICIO) && !borda && (cnt_q == CNT_MAX);

    always_comb begin
        s1_d       = s0_q;
        cnt_d      = borda ? CNT_UM : cnt_q + CNT_UM;
        estado_d   = estado_q;
        alto_cur_d = alto_cur_q;
        alto_d     = alto_q;
        baixo_d    = baixo_q;
        periodo_d  = periodo_q;
        valido_d   = 1'b0;
        travado_d  = travado_q;
        erro_d     = erro_q;
        acerto_d   = acerto_q;
        ha_ref_d   = ha_ref_q;

        unique case (estado_q)
            INICIO: begin
                if (subida) begin
                    estado_d = ALTO;
                end
            end
            ALTO: begin
                if (descida) begin
                    alto_cur_d = cnt_q;
                    estado_d   = BAIXO;
                end
            end
            BAIXO: begin
                if (subida) begin
                    alto_d    = alto_cur_q;
                    baixo_d   = cnt_q;
                    periodo_d = {1'b0, alto_cur_q} + {1'b0, cnt_q};
                    valido_d  = 1'b1;
                    ha_ref_d  = 1'b1;
                    // The first period after reset/overflow only seeds the
                    // reference held in alto_q/baixo_q.
                    if (ha_ref_q && alto_cur_q == alto_q
                        && cnt_q == baixo_q) begin
                        if (acerto_q != ACERTO_MAX) begin
                            acerto_d = acerto_q + AW'(1);
                        end
                    end else begin
                        acerto_d = '0;
                    end
                    travado_d = (acerto_d == ACERTO_MAX);
                    estado_d  = ALTO;
                end
            end
            default: begin
                estado_d = INICIO;
            end
        endcase

        if (estouro) begin
            erro_d    = 1'b1;
            estado_d  = INICIO;
            acerto_d  = '0;
            travado_d = 1'b0;
            ha_ref_d  = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            cnt_q      <= '0;
            estado_q   <= INICIO;
            alto_cur_q <= '0;
            alto_q     <= '0;
            baixo_q    <= '0;
            periodo_q  <= '0;
            valido_q   <= 1'b0;
            travado_q  <= 1'b0;
            erro_q     <= 1'b0;
            acerto_q   <= '0;
            ha_ref_q   <= 1'b0;
        end else begin
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            cnt_q      <= cnt_d;
            estado_q   <= estado_d;
            alto_cur_q <= alto_cur_d;
            alto_q     <= alto_d;
            baixo_q    <= baixo_d;
            periodo_q  <= periodo_d;
            valido_q   <= valido_d;
            travado_q  <= travado_d;
            erro_q     <= erro_d;
            acerto_q   <= acerto_d;
            ha_ref_q   <= ha_ref_d;
        end
    end

    assign Alto    = alto_q;
    assign Baixo   = baixo_q;
    assign Periodo = periodo_q;
    assign Valido  = valido_q;
    assign Travado = travado_q;
    assign Erro    = erro_q;

endmodule
